if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipeline CPU. Holds the program counter, drives the instruction-memory address, and registers the fetched instruction and PC+4 into the decode stage. Decode reads its register, immediate and opcode fields from this block's outputs; the low 16 bits of `instr_id` feed the sign-extension unit directly.

## Interface
- `WIDTH_I`, 32: instruction and address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset. Must be word-aligned.
- `NOP_INSTR`, 32'h0000_0000: value loaded into `instr_id` on reset and on bubble.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `branch_taken`  in  1  decode stage resolved a taken branch or jump this cycle.
- `branch_target`  in  WIDTH_I  redirect address; bits [1:0] are ignored.
- `imem_rdata`  in  WIDTH_I  instruction memory read data (combinational read of `imem_addr`).
- `imem_addr`  out  WIDTH_I  current PC; bits [1:0] always 0.
- `instr_id`  out  WIDTH_I  registered instruction to decode.
- `pc_plus4_id`  out  WIDTH_I  registered PC+4 of `instr_id`.
- `valid_id`  out  1  1 when `instr_id` is a real fetched instruction, 0 for a bubble.

## Operation
- PC register `pc`; `imem_addr = pc` combinationally.
- `pc_plus4 = pc + 4`, modulo 2^WIDTH_I: 32'hFFFF_FFFC wraps to 0.
- Effective redirect: `redir = branch_taken & ~stall`.
  - A stalled branch is not taken this cycle.
  - Decode holds the branch and reasserts `branch_taken` after the stall clears.
- Next PC, in priority order:
  1. `stall`: hold `pc`.
  2. `redir`: load `{branch_target[WIDTH_I-1:2], 2'b00}`.
  3. Otherwise: load `pc_plus4`.
- IF/ID register, in priority order:
  1. `stall`: hold `instr_id`, `pc_plus4_id` and `valid_id`.
  2. `redir`: behaviour depends on `DELAY_SLOT_EN` (see Configuration).
  3. Otherwise: `instr_id <= imem_rdata`, `pc_plus4_id <= pc_plus4`, `valid_id <= 1`.
- Bubble: `instr_id <= NOP_INSTR`, `pc_plus4_id <= pc_plus4`, `valid_id <= 0`.
- No FSM beyond the PC/IF-ID registers. The block is a two-register pipeline front end with stall and redirect control.

## Timing
- Reset (`rst_n` low, asynchronous, effective immediately even mid-cycle):
  - `pc = RESET_PC`, so `imem_addr = RESET_PC`.
  - `instr_id = NOP_INSTR`, `pc_plus4_id = 0`, `valid_id = 0`.
- First edge after `rst_n` rises:
  - `instr_id = mem[RESET_PC]`, `pc_plus4_id = RESET_PC+4`, `valid_id = 1`.
  - `pc = RESET_PC+4`.
- Fetch-to-decode latency: 1 cycle. The instruction at address A appears on `instr_id` on the edge after `pc == A` with no stall.
- Stall of N cycles: outputs and `pc` frozen for N edges, then the stream resumes with no instruction lost or duplicated.
- Redirect, when `redir` is high at edge k: `pc == target` after edge k, and `instr_id = mem[target]` after edge k+1.
- `stall` and `branch_taken` high together: the stall wins completely; the branch has no effect in that cycle.
- `branch_taken` held high for consecutive non-stalled cycles: each cycle is a fresh redirect. Decode is responsible for deasserting it.
- `branch_target` equal to the current PC: legal; produces a tight loop.

## Configuration
- Macro `IF_ID_DELAY_SLOT_EN` controls MIPS branch-delay-slot handling.
- Defined:
  - On `redir`, IF/ID loads the instruction currently being fetched (the delay slot) normally: `instr_id <= imem_rdata`, `valid_id <= 1`.
  - Zero bubble per taken branch.
- Undefined (default):
  - On `redir`, IF/ID loads a bubble (`NOP_INSTR`, `valid_id = 0`), squashing the wrong-path instruction.
  - One bubble per taken branch.

## Test plan
- Reset then free run, with memory word at byte address 4i holding 32'h1000_0000+i: `instr_id` sequence 0x10000000, 0x10000001, 0x10000002…; `pc_plus4_id` 4, 8, 12; `valid_id` = 1 from the first edge.
- Stall for 3 cycles while `instr_id` = 0x10000002: outputs and `imem_addr` = 0x0C frozen for 3 edges, then 0x10000003 follows with no gap.
- `branch_taken` with target 0x40 while `pc` = 0x10:
  - Default: one bubble (`valid_id` = 0, `instr_id` = NOP), then mem[0x40].
  - With `IF_ID_DELAY_SLOT_EN`: mem[0x10] then mem[0x40].
- `stall` = 1 and `branch_taken` = 1 in the same cycle, target 0x80: `pc` unchanged; the redirect takes effect only in the next non-stalled cycle in which `branch_taken` is high.
- Unaligned target 0x43: `imem_addr` becomes 0x40.
- Wrap-around: PC at 0xFFFF_FFFC advances to 0x0, and `pc_plus4_id` = 0x0 for that instruction.
- `rst_n` pulsed low mid-cycle during a stall: outputs clear immediately to their reset values, and fetch restarts from `RESET_PC`.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, fetch address, stall/redirect control.
// Optional macro IF_ID_DELAY_SLOT_EN keeps the delay-slot instruction on a taken branch instead of squashing it.
module if_id_stage #(
   parameter int                 WIDTH_I   = 32,
   parameter logic [WIDTH_I-1:0] RESET_PC  = '0,
   parameter logic [WIDTH_I-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [WIDTH_I-1:0] branch_target,
   input  logic [WIDTH_I-1:0] imem_rdata,
   output logic [WIDTH_I-1:0] imem_addr,
   output logic [WIDTH_I-1:0] instr_id,
   output logic [WIDTH_I-1:0] pc_plus4_id,
   output logic               valid_id
);

   logic [WIDTH_I-1:0] pc_q, pc_d;
   logic [WIDTH_I-1:0] instr_q, instr_d;
   logic [WIDTH_I-1:0] pc4_id_q, pc4_id_d;
   logic               valid_q, valid_d;
   logic [WIDTH_I-1:0] pc_plus4;
   logic               redir;

   assign pc_plus4 = pc_q + WIDTH_I'(4);
   // A stalled branch is ignored; decode re-presents it once the stall clears.
   assign redir    = branch_taken & ~stall;

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc4_id_d = pc4_id_q;
      valid_d  = valid_q;
      if (!stall) begin
         pc4_id_d = pc_plus4;
         if (redir) begin
            pc_d = branch_target & ~WIDTH_I'(3);
`ifdef IF_ID_DELAY_SLOT_EN
            instr_d = imem_rdata;
            valid_d = 1'b1;
`else
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
`endif
         end else begin
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc4_id_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_id_q <= pc4_id_d;
         valid_q  <= valid_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr_id    = instr_q;
   assign pc_plus4_id = pc4_id_q;
   assign valid_id    = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random stall/branch traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_if_id_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] instr_id;
   logic [31:0] pc_plus4_id;
   logic        valid_id;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;

   if_id_stage #(
      .WIDTH_I  (32),
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_rdata   (imem_rdata),
      .imem_addr    (imem_addr),
      .instr_id     (instr_id),
      .pc_plus4_id  (pc_plus4_id),
      .valid_id     (valid_id)
   );

   always #5 clk = ~clk;

   // Word at byte address 4i holds 0x1000_0000 + i
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  imem_addr,   m_pc);
      check({tag, ".instr"}, instr_id,    m_instr);
      check({tag, ".pc4"},   pc_plus4_id, m_pc4);
      check({tag, ".valid"}, {31'b0, valid_id}, {31'b0, m_valid});
      $display("%-10s st=%0b bt=%0b tgt=%08h addr=%08h instr=%08h pc4=%08h v=%0b",
               tag, stall, branch_taken, branch_target, imem_addr, instr_id, pc_plus4_id, valid_id);
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 32'h0; m_valid = 1'b0;
   endtask

   // One clock edge: drive inputs, advance the model by the fetch rules, check 1 time unit after the edge.
   task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t);
      stall = s; branch_taken = b; branch_target = t;
      @(posedge clk);
      if (!s) begin
         m_pc4 = m_pc + 32'd4;
         if (b) begin
`ifdef IF_ID_DELAY_SLOT_EN
            m_instr = mem_word(m_pc); m_valid = 1'b1;
`else
            m_instr = NOP_INSTR; m_valid = 1'b0;
`endif
            m_pc = {t[31:2], 2'b00};
         end else begin
            m_instr = mem_word(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Free run
      step("run0", 0, 0, 0);
      check("run0.lit", instr_id, 32'h1000_0000);
      step("run1", 0, 0, 0);
      step("run2", 0, 0, 0);
      check("run2.lit", instr_id, 32'h1000_0002);

      // Three-cycle stall at pc 0x0C
      for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
      check("stall.addr.lit", imem_addr, 32'h0000_000C);
      step("resume", 0, 0, 0);
      check("resume.lit", instr_id, 32'h1000_0003);

      // Taken branch at pc 0x10 to 0x40
      step("br40", 0, 1, 32'h40);
      check("br40.addr.lit", imem_addr, 32'h40);
      step("br40+1", 0, 0, 0);
      check("br40+1.lit", instr_id, 32'h1000_0010);

      // Stall and branch together: stall wins
      step("stbr", 1, 1, 32'h80);
      step("stbr2", 1, 1, 32'h80);
      step("br80", 0, 1, 32'h80);
      check("br80.addr.lit", imem_addr, 32'h80);
      step("br80+1", 0, 0, 0);

      // Unaligned target and tight loop
      step("br43", 0, 1, 32'h43);
      check("br43.lit", imem_addr, 32'h40);
      step("loop", 0, 1, 32'h40);
      step("loop2", 0, 0, 0);

      // Wrap-around
      step("brtop", 0, 1, 32'hFFFF_FFFC);
      step("wrap", 0, 0, 0);
      check("wrap.pc4.lit", pc_plus4_id, 32'h0);
      check("wrap.addr.lit", imem_addr, 32'h0);
      step("wrap2", 0, 0, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic s, b;
         logic [31:0] t;
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 4) == 0);
         t = ($urandom_range(0, 1) == 0) ? ($urandom() & 32'h0000_03FF) : $urandom();
         step("rand", s, b, t);
      end

      // Asynchronous reset mid-cycle during a stall
      step("prerst", 1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("midrst");
      @(negedge clk);
      stall = 1'b0;
      rst_n = 1'b1;
      step("rst0", 0, 0, 0);
      check("rst0.lit", instr_id, 32'h1000_0000);
      step("rst1", 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
